// File: rtl/stream_dot_pkg.sv
// Shared helpers for the streaming dot-product engine.
//   acc_width_ok : elaboration-time check that the accumulator cannot overflow over one block
//   cnt_width    : width of the beat counter for a given beats-per-block (minimum 1)
//   fmt          : result formatting (saturate or wrap) on a 64-bit extended accumulator value
package stream_dot_pkg;

  localparam int unsigned MaxW = 64;

  function automatic bit acc_width_ok(input int unsigned acc_w, input int unsigned data_w,
                                      input int unsigned weight_w, input int unsigned bdim);
    return acc_w >= data_w + weight_w + $clog2(bdim);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

  // v must already be sign- or zero-extended to MaxW; caller keeps the low out_w bits.
  function automatic logic [MaxW-1:0] fmt(input logic [MaxW-1:0] v, input bit is_signed,
                                          input bit saturate, input int unsigned out_w);
    logic [MaxW-1:0] hi;
    logic [MaxW-1:0] lo;
    if (!saturate) return v;
    if (is_signed) begin
      hi = (MaxW'(1) << (out_w - 1)) - MaxW'(1);
      lo = ~hi;  // -(2^(out_w-1)) in two's complement
      if ($signed(v) > $signed(hi)) return hi;
      if ($signed(v) < $signed(lo)) return lo;
      return v;
    end else begin
      hi = (out_w >= MaxW) ? '1 : (MaxW'(1) << out_w) - MaxW'(1);
      if (v > hi) return hi;
      return v;
    end
  endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Combinational reduction of Lanes products into one SumW-bit sum.
//   prods_i : Lanes products, lane i at [i*ProdW +: ProdW]
//   sum_o   : sum of all lanes, each sign- (Signed=1) or zero-extended to SumW first
module dot_adder_tree #(
  parameter int unsigned Lanes  = 4,
  parameter int unsigned ProdW  = 24,
  parameter int unsigned SumW   = 32,
  parameter bit          Signed = 1'b1
) (
  input  logic [Lanes*ProdW-1:0] prods_i,
  output logic [SumW-1:0]        sum_o
);

  // Leaves padded with zeros up to a power of two so the tree is always balanced.
  localparam int unsigned Leaves = (Lanes <= 1) ? 1 : 2 ** $clog2(Lanes);

  always_comb begin
    logic [SumW-1:0] node [2*Leaves];
    for (int k = 0; k < 2 * int'(Leaves); k++) node[k] = '0;
    for (int i = 0; i < int'(Lanes); i++) begin
      node[int'(Leaves) + i] = Signed ? SumW'($signed(prods_i[i*ProdW +: ProdW]))
                                      : SumW'(prods_i[i*ProdW +: ProdW]);
    end
    for (int k = int'(Leaves) - 1; k >= 1; k--) node[k] = node[2*k] + node[2*k+1];
    sum_o = (Leaves == 1) ? node[Leaves] : node[1];
  end

endmodule

// File: rtl/stream_dot_pe.sv
// Streaming dot-product engine: SDIM multiply lanes per beat, adder-tree reduction, accumulation
// over BDIM elements, one formatted result per block.
//   ap_clk, ap_rst_n                : clock, async active-low reset
//   s_axis_input_*                  : SDIM x DATA_WIDTH input beats
//   s_axis_weights_*                : SDIM x WEIGHT_WIDTH weight beats (transfer together with input)
//   m_axis_output_*                 : OUT_WIDTH result per block, held under backpressure
module stream_dot_pe
  import stream_dot_pkg::*;
#(
  parameter int unsigned s_axis_input_BDIM   = 64,
  parameter int unsigned s_axis_input_SDIM   = 4,
  parameter int unsigned s_axis_weights_BDIM = 64,
  parameter int unsigned s_axis_weights_SDIM = 4,
  parameter int unsigned m_axis_output_BDIM  = 1,
  parameter int unsigned DATA_WIDTH          = 16,
  parameter int unsigned WEIGHT_WIDTH        = 8,
  parameter int unsigned ACC_WIDTH           = 32,
  parameter int unsigned OUT_WIDTH           = 16,
  parameter bit          SIGNED              = 1'b1,
  parameter bit          SATURATE            = 1'b1
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst_n,
  input  logic [s_axis_input_SDIM*DATA_WIDTH-1:0] s_axis_input_tdata,
  input  logic                                    s_axis_input_tvalid,
  output logic                                    s_axis_input_tready,
  input  logic [s_axis_input_SDIM*WEIGHT_WIDTH-1:0] s_axis_weights_tdata,
  input  logic                                    s_axis_weights_tvalid,
  output logic                                    s_axis_weights_tready,
  output logic [OUT_WIDTH-1:0]                    m_axis_output_tdata,
  output logic                                    m_axis_output_tvalid,
  input  logic                                    m_axis_output_tready
);

  localparam int unsigned Sdim  = s_axis_input_SDIM;
  localparam int unsigned Beats = s_axis_input_BDIM / s_axis_input_SDIM;
  localparam int unsigned ProdW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned CntW  = cnt_width(Beats);
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  if (s_axis_input_BDIM % s_axis_input_SDIM != 0) begin : g_err_bdim
    $error("s_axis_input_BDIM must be a multiple of s_axis_input_SDIM");
  end
  if (s_axis_weights_BDIM != s_axis_input_BDIM) begin : g_err_wbdim
    $error("s_axis_weights_BDIM must equal s_axis_input_BDIM");
  end
  if (s_axis_weights_SDIM != s_axis_input_SDIM) begin : g_err_wsdim
    $error("s_axis_weights_SDIM must equal s_axis_input_SDIM");
  end
  if (m_axis_output_BDIM != 1) begin : g_err_obdim
    $error("m_axis_output_BDIM must be 1");
  end
  if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH, WEIGHT_WIDTH, s_axis_input_BDIM)) begin : g_err_acc
    $error("ACC_WIDTH too small for DATA_WIDTH+WEIGHT_WIDTH+clog2(BDIM)");
  end
  if (ACC_WIDTH > MaxW || OUT_WIDTH > ACC_WIDTH) begin : g_err_out
    $error("require OUT_WIDTH <= ACC_WIDTH <= 64");
  end

  logic stall, accept, first, last;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [ACC_WIDTH-1:0] s1_sum_q, s1_sum_d, acc_q, acc_d, acc_next, tree_sum;
  logic [MaxW-1:0] acc_ext, fmt_full;
  logic out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [Sdim*ProdW-1:0] prods;

  assign stall  = out_valid_q && !m_axis_output_tready;
  assign accept = s_axis_input_tvalid && s_axis_weights_tvalid && !stall;
  // Readys are cross-coupled so both streams transfer on the same edge or not at all.
  assign s_axis_input_tready   = ap_rst_n && s_axis_weights_tvalid && !stall;
  assign s_axis_weights_tready = ap_rst_n && s_axis_input_tvalid && !stall;
  assign first = (cnt_q == '0);
  assign last  = (cnt_q == LastCnt);

  for (genvar i = 0; i < Sdim; i++) begin : g_lane
    logic [DATA_WIDTH-1:0]   a;
    logic [WEIGHT_WIDTH-1:0] b;
    logic [ProdW-1:0]        a_ext, b_ext;
    assign a = s_axis_input_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign b = s_axis_weights_tdata[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign a_ext = SIGNED ? {{WEIGHT_WIDTH{a[DATA_WIDTH-1]}}, a} : {{WEIGHT_WIDTH{1'b0}}, a};
    assign b_ext = SIGNED ? {{DATA_WIDTH{b[WEIGHT_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
    // Low ProdW bits of the product are exact for both signed and unsigned operands.
    assign prods[i*ProdW +: ProdW] = a_ext * b_ext;
  end

  dot_adder_tree #(
    .Lanes  (Sdim),
    .ProdW  (ProdW),
    .SumW   (ACC_WIDTH),
    .Signed (SIGNED)
  ) u_tree (
    .prods_i (prods),
    .sum_o   (tree_sum)
  );

  assign acc_next = (s1_first_q ? '0 : acc_q) + s1_sum_q;
  assign acc_ext  = SIGNED ? MaxW'($signed(acc_next)) : MaxW'(acc_next);
  assign fmt_full = fmt(acc_ext, SIGNED, SATURATE, OUT_WIDTH);

  always_comb begin
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_sum_d    = s1_sum_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) cnt_d = last ? '0 : cnt_q + 1'b1;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_sum_d   = tree_sum;
        s1_first_d = first;
        s1_last_d  = last;
      end
    end
    if (m_axis_output_tready) out_valid_d = 1'b0;
    // A new result overrides the handshake clear in the same cycle.
    if (s1_valid_q && !stall) begin
      acc_d = acc_next;
      if (s1_last_q) begin
        out_valid_d = 1'b1;
        out_data_d  = fmt_full[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_axis_output_tvalid = out_valid_q;
  assign m_axis_output_tdata  = out_data_q;

endmodule

// File: tb/tb_stream_dot_pe.sv
module tb_stream_dot_pe;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic [3:0][15:0] in_data = '0;
  logic [3:0][7:0]  wt_data = '0;
  logic in_valid = 1'b0, wt_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, wt_ready, out_valid;
  logic in_ready2, wt_ready2, out_valid2;
  logic [15:0] out_data, out_data2;

  always #5 ap_clk = ~ap_clk;

  // Saturating instance
  stream_dot_pe #(
    .s_axis_input_BDIM(8), .s_axis_input_SDIM(4), .s_axis_weights_BDIM(8),
    .s_axis_weights_SDIM(4), .m_axis_output_BDIM(1), .DATA_WIDTH(16), .WEIGHT_WIDTH(8),
    .ACC_WIDTH(32), .OUT_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)
  ) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_input_tdata(in_data), .s_axis_input_tvalid(in_valid), .s_axis_input_tready(in_ready),
    .s_axis_weights_tdata(wt_data), .s_axis_weights_tvalid(wt_valid),
    .s_axis_weights_tready(wt_ready),
    .m_axis_output_tdata(out_data), .m_axis_output_tvalid(out_valid),
    .m_axis_output_tready(out_ready)
  );

  // Wrapping instance, same stimulus
  stream_dot_pe #(
    .s_axis_input_BDIM(8), .s_axis_input_SDIM(4), .s_axis_weights_BDIM(8),
    .s_axis_weights_SDIM(4), .m_axis_output_BDIM(1), .DATA_WIDTH(16), .WEIGHT_WIDTH(8),
    .ACC_WIDTH(32), .OUT_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)
  ) u_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_input_tdata(in_data), .s_axis_input_tvalid(in_valid), .s_axis_input_tready(in_ready2),
    .s_axis_weights_tdata(wt_data), .s_axis_weights_tvalid(wt_valid),
    .s_axis_weights_tready(wt_ready2),
    .m_axis_output_tdata(out_data2), .m_axis_output_tvalid(out_valid2),
    .m_axis_output_tready(out_ready)
  );

  typedef struct {
    logic [15:0] sat;
    logic [15:0] wrap;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [7:0]  w;
    logic [15:0] sat;
    logic [15:0] wrap;
  } vec_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0][15:0] d, input logic [7:0][7:0] w);
    longint s = 0;
    exp_t   e;
    for (int i = 0; i < 8; i++) s += longint'($signed(d[i])) * longint'($signed(w[i]));
    if (s > 32767) e.sat = 16'h7fff;
    else if (s < -32768) e.sat = 16'h8000;
    else e.sat = s[15:0];
    e.wrap = s[15:0];
    return e;
  endfunction

  function automatic logic [7:0][15:0] fill_d(input logic [15:0] v);
    logic [7:0][15:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [7:0][7:0] fill_w(input logic [7:0] v);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  // Output scoreboard: compare every handshaken result against the queue head.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, required no result", out_data);
      end else begin
        e = sb.pop_front();
        check("result_sat", 32'(out_data), 32'(e.sat));
        check("result_wrap", 32'(out_data2), 32'(e.wrap));
        check("result_wrap_valid", 32'(out_valid2), 32'd1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge, valids still high.
  task automatic send_beat(input logic [3:0][15:0] d, input logic [3:0][7:0] w,
                           input bit push, input exp_t e);
    bit ok = 1'b0;
    in_data = d; wt_data = w; in_valid = 1'b1; wt_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge ap_clk);
      if (in_ready && wt_ready) begin
        ok = 1'b1;
        if (push) sb.push_back(e);
      end
      @(posedge ap_clk); #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: got no handshake, required one within 200 cycles");
    end
  endtask

  task automatic send_block(input logic [7:0][15:0] d, input logic [7:0][7:0] w, input exp_t e);
    logic [3:0][15:0] d0, d1;
    logic [3:0][7:0]  w0, w1;
    d0 = d[3:0]; d1 = d[7:4]; w0 = w[3:0]; w1 = w[7:4];
    send_beat(d0, w0, 1'b0, e);
    send_beat(d1, w1, 1'b1, e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    wt_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(posedge ap_clk);
      c++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200us");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    exp_t e;
    logic [7:0][15:0] d;
    logic [7:0][7:0]  w;
    logic [3:0][15:0] bd;
    logic [3:0][7:0]  bw;

    vecs[0] = '{"ones_twos",   16'h0001, 8'h02, 16'h0010, 16'h0010};
    vecs[1] = '{"signed_neg",  16'hfffd, 8'h05, 16'hff88, 16'hff88};
    vecs[2] = '{"sat_pos",     16'h7fff, 8'h7f, 16'h7fff, 16'hfc08};
    vecs[3] = '{"sat_neg",     16'h8000, 8'h7f, 16'h8000, 16'h0000};
    vecs[4] = '{"neg_neg",     16'hffff, 8'hff, 16'h0008, 16'h0008};
    vecs[5] = '{"sat_neg_mix", 16'h0064, 8'h80, 16'h8000, 16'h7000};
    vecs[6] = '{"zeros",       16'h0000, 8'h55, 16'h0000, 16'h0000};

    // Reset state, with valids high to show readys are held low.
    in_valid = 1'b1; wt_valid = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_data_wrap", 32'(out_data2), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wt_ready", 32'(wt_ready), 32'd0);
    idle();
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Latency: last beat handshake cycle t -> tvalid in cycle t+2.
    e = '{16'h0010, 16'h0010};
    send_block(fill_d(16'h0001), fill_w(8'h02), e);
    idle();
    @(negedge ap_clk);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge ap_clk);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    @(posedge ap_clk); #1;
    drain();

    // Table of uniform blocks, back to back.
    foreach (vecs[i]) begin
      e = '{vecs[i].sat, vecs[i].wrap};
      send_block(fill_d(vecs[i].d), fill_w(vecs[i].w), e);
    end
    idle();
    drain();

    // Per-lane distinct random blocks.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) begin
        d[i] = 16'($urandom);
        w[i] = 8'($urandom);
      end
      send_block(d, w, model(d, w));
    end
    idle();
    drain();

    // Unbalanced valids: weights alone must not advance the beat counter.
    e = '{16'd48, 16'd48};
    d = fill_d(16'd2); w = fill_w(8'd3);
    bd = d[3:0]; bw = w[3:0];
    send_beat(bd, bw, 1'b0, e);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      check("unbal_wt_ready", 32'(wt_ready), 32'd0);
      check("unbal_in_ready", 32'(in_ready), 32'd1);
      @(posedge ap_clk); #1;
    end
    bd = d[7:4]; bw = w[7:4];
    send_beat(bd, bw, 1'b1, e);
    idle();
    drain();

    // Backpressure: three blocks while the consumer stalls for 10 cycles.
    out_ready = 1'b0;
    fork
      begin
        send_block(fill_d(16'd1), fill_w(8'd1), '{16'd8, 16'd8});
        send_block(fill_d(16'd2), fill_w(8'd2), '{16'd32, 16'd32});
        send_block(fill_d(16'hfffb), fill_w(8'd7), '{16'hfee8, 16'hfee8});
        idle();
      end
      begin
        int c = 0;
        while (!out_valid && c < 40) begin
          @(negedge ap_clk);
          c++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
          check("bp_hold_data", 32'(out_data), 32'd8);
          check("bp_hold_valid", 32'(out_valid), 32'd1);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_wt_ready", 32'(wt_ready), 32'd0);
          @(negedge ap_clk);
        end
        @(posedge ap_clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-block: partial block discarded.
    d = fill_d(16'd1); w = fill_w(8'd3);
    bd = d[3:0]; bw = w[3:0];
    send_beat(bd, bw, 1'b0, e);
    #2 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_wt_ready", 32'(wt_ready), 32'd0);
    idle();
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    send_block(fill_d(16'd1), fill_w(8'd3), '{16'd24, 16'd24});
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_dot_pe.md
Name: stream_dot_pe

Overview:
- Streaming dot-product engine with SDIM parallel multiply lanes.
- Each beat carries SDIM input and SDIM weight elements; products are reduced by an adder tree and accumulated over a block of BDIM elements.
- One saturated or truncated result is emitted per block on the output stream.
- Sits between the input and weight AXI-Stream sources and the downstream output consumer in kernel datapaths; adds signedness, saturation, full backpressure and block framing.

Parameters:
- s_axis_input_BDIM, 64, elements per block (dot-product length); must be a multiple of s_axis_input_SDIM.
- s_axis_input_SDIM, 4, elements per input beat (lane count).
- s_axis_weights_BDIM, 64, must equal s_axis_input_BDIM (elaboration error otherwise).
- s_axis_weights_SDIM, 4, must equal s_axis_input_SDIM (elaboration error otherwise).
- m_axis_output_BDIM, 1, results per block; only 1 supported (elaboration error otherwise).
- DATA_WIDTH, 16, input element width.
- WEIGHT_WIDTH, 8, weight element width.
- ACC_WIDTH, 32, accumulator width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(BDIM) (elaboration error otherwise).
- OUT_WIDTH, 16, result width; must be <= ACC_WIDTH.
- SIGNED, 1, 1 = two's-complement operands and result, 0 = unsigned.
- SATURATE, 1, 1 = clamp result to OUT_WIDTH range, 0 = keep low OUT_WIDTH bits.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- s_axis_input_tdata  in  SDIM*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_input_tvalid  in  1  input beat valid
- s_axis_input_tready  out  1  input beat accepted
- s_axis_weights_tdata  in  SDIM*WEIGHT_WIDTH  lane i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- s_axis_weights_tvalid  in  1  weight beat valid
- s_axis_weights_tready  out  1  weight beat accepted
- m_axis_output_tdata  out  OUT_WIDTH  block result
- m_axis_output_tvalid  out  1  result valid
- m_axis_output_tready  in  1  downstream ready

Behaviour:
- Reset is async assert, sync deassert. It clears:
  - beat counter, stage-1 valid, accumulator;
  - m_axis_output_tvalid and m_axis_output_tdata (to 0).
- Any partial block in flight at reset is discarded.
- Stall and ready:
  - stall = m_axis_output_tvalid && !m_axis_output_tready.
  - s_axis_input_tready = s_axis_weights_tvalid && !stall.
  - s_axis_weights_tready = s_axis_input_tvalid && !stall.
  - Both streams therefore transfer on the same cycle, or neither does.
  - Both readys are 0 during reset.
- Beat acceptance: accept = both tvalid && !stall.
  - Beat counter runs 0..BEATS-1, where BEATS = BDIM/SDIM, and wraps to 0 after the last beat.
  - first = (cnt==0); last = (cnt==BEATS-1).
- Stage 1 (registered on accept):
  - Per-lane product, sign- or zero-extended according to SIGNED.
  - Adder-tree sum registered in a sum register, together with valid, first and last flags.
  - A cycle with no accept and no stall loads stage-1 valid = 0.
- Stage 2 (when stage-1 valid && !stall):
  - acc_next = (first ? 0 : acc) + sum.
  - If last: output register loads fmt(acc_next) and tvalid goes to 1; acc is loaded with acc_next, and the next first beat clears it.
- Stall freezes the counter, stage 1 and the accumulator. No beat is lost or duplicated.
- Latency: a last beat accepted at cycle t gives m_axis_output_tvalid=1 at cycle t+2.
- Throughput: one beat per cycle; one result every BEATS cycles when unstalled.
- Output register:
  - Holds tdata stable while tvalid && !tready.
  - Clears tvalid on a tready handshake unless a new result loads in the same cycle; in that case it reloads and tvalid stays 1.
- fmt():
  - SATURATE=1, SIGNED=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - SATURATE=1, SIGNED=0: clamp to [0, 2^OUT_WIDTH-1].
  - SATURATE=0: acc_next[OUT_WIDTH-1:0].
- BEATS=1: every beat is both first and last.

Decomposition:
- Shared package stream_dot_pkg holds:
  - the clog2-based ACC_WIDTH minimum-check function;
  - the saturation function fmt(), parametrised by SIGNED and OUT_WIDTH;
  - beat-counter width constant: clog2(BEATS), minimum 1.
- One sub-module: dot_adder_tree (SDIM products in, one ACC_WIDTH sum out, combinational, sign-aware).

Test Plan:
- Basic: SDIM=4, BDIM=8, all inputs 1, all weights 2, two beats, tready=1 -> single result 16, tvalid exactly 2 cycles after the second beat.
- Signed: SIGNED=1, inputs -3, weights 5, BDIM=8 -> result -120 (0xFF88).
- Saturation: SIGNED=1, inputs 0x7FFF, weights 127, BDIM=8:
  - SATURATE=1 -> 0x7FFF;
  - SATURATE=0 -> 0xFC08.
- Backpressure: 3 back-to-back blocks with distinct values, m_axis_output_tready held low 10 cycles -> first result stable, both readys low, then all 3 results emitted in order, none lost.
- Unbalanced valids: weights valid with input invalid for 5 cycles -> no handshake, counter unchanged; result correct once input arrives.
- Reset mid-block: assert ap_rst_n=0 after 1 of 2 beats -> all outputs 0 immediately; the next full block (ones x 3) yields 24, with no residue from the partial block.
